// File: rtl/hazard_tnew_tracker.sv
// Tuse/Tnew hazard tracker: shadows producer dst/Tnew through E/M/W, emits D-stage stall and fwd selects.
// Latency: all outputs combinational from shadow state + D inputs; shadow state advances one stage per clk.
// Backpressure: stall freezes D upstream and injects a bubble into shadow E; M and W keep draining.
module hazard_tnew_tracker #(
  parameter int REG_W = 5,
  parameter int T_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [T_W-1:0]   D_tuse_rs,
  input  logic [T_W-1:0]   D_tuse_rt,
  input  logic             D_regwr,
  input  logic [REG_W-1:0] D_dst,
  input  logic [T_W-1:0]   D_tnew,
  output logic             stall,
  output logic [1:0]       fwd_D_rs,
  output logic [1:0]       fwd_D_rt,
  output logic [1:0]       fwd_E_rs,
  output logic [1:0]       fwd_E_rt,
  output logic [1:0]       fwd_M_rt
);

  // Tuse all-ones means the operand is never read.
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_E  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_W  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic             regwr;
    logic [REG_W-1:0] dst;
    logic [T_W-1:0]   tnew;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } stage_t;

  stage_t e_q, e_d;
  stage_t m_q, m_d;
  stage_t w_q, w_d;

  // A producer satisfies register r only if it really writes r and r is not $0.
  function automatic logic hit(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid && s.regwr && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // A source stalls when an in-flight producer's result arrives later than the consumer needs it.
  function automatic logic src_stall(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse,
                                     input stage_t e, input stage_t m);
    if (tuse == TUSE_NONE) return 1'b0;
    return (hit(e, r) && (e.tnew > tuse)) || (hit(m, r) && (m.tnew > tuse));
  endfunction

  // Nearest producer wins; if it is not ready yet, read RF and rely on stall to hold D.
  function automatic logic [1:0] d_sel(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse,
                                       input stage_t e, input stage_t m, input stage_t w);
    if (tuse == TUSE_NONE) return SEL_RF;
    if (hit(e, r)) return (e.tnew == '0) ? SEL_E : SEL_RF;
    if (hit(m, r)) return (m.tnew == '0) ? SEL_M : SEL_RF;
    if (hit(w, r)) return SEL_W;
    return SEL_RF;
  endfunction

  // Operands already in E can only be refreshed from a ready M result or from W.
  function automatic logic [1:0] e_sel(input logic [REG_W-1:0] r, input stage_t m, input stage_t w);
    if (hit(m, r) && (m.tnew == '0)) return SEL_M;
    if (hit(w, r)) return SEL_W;
    return SEL_RF;
  endfunction

  // Hazard detection and forwarding selects.
  always_comb begin
    stall    = D_valid && (src_stall(D_rs, D_tuse_rs, e_q, m_q) ||
                           src_stall(D_rt, D_tuse_rt, e_q, m_q));
    fwd_D_rs = d_sel(D_rs, D_tuse_rs, e_q, m_q, w_q);
    fwd_D_rt = d_sel(D_rt, D_tuse_rt, e_q, m_q, w_q);
    fwd_E_rs = e_sel(e_q.rs, m_q, w_q);
    fwd_E_rt = e_sel(e_q.rt, m_q, w_q);
    fwd_M_rt = hit(w_q, m_q.rt) ? SEL_W : SEL_RF;
  end

  // Next stage contents: bubble into E on stall, Tnew counts down as producers move on.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.valid = D_valid;
      e_d.regwr = D_regwr;
      e_d.dst   = D_dst;
      e_d.tnew  = D_tnew;
      e_d.rs    = D_rs;
      e_d.rt    = D_rt;
    end
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = '0;
  end

  // Stage registers; reset empties the whole shadow pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Fields carried for completeness of each stage record but never consulted downstream.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew};

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Bench for hazard_tnew_tracker: directed scenarios then random D traffic with random async resets.
module tb_hazard_tnew_tracker;

  logic       clk;
  logic       reset;
  logic       D_valid;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_regwr;
  logic       stall;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  int total = 0;
  int bad   = 0;

  hazard_tnew_tracker #(.REG_W(5), .T_W(2)) dut (
    .clk(clk), .reset(reset),
    .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_regwr(D_regwr), .D_dst(D_dst), .D_tnew(D_tnew),
    .stall(stall),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0=E, 1=M, 2=W.
  typedef struct {
    bit valid;
    bit regwr;
    int dst;
    int tnew;
    int rs;
    int rt;
  } rec_t;

  rec_t pipe [3];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
  endtask

  function automatic bit produces(int k, int r);
    return pipe[k].valid && pipe[k].regwr && (pipe[k].dst == r) && (r != 0);
  endfunction

  function automatic bit m_stall();
    int regs [2];
    int tuses [2];
    bit s;
    regs[0] = int'(D_rs);  tuses[0] = int'(D_tuse_rs);
    regs[1] = int'(D_rt);  tuses[1] = int'(D_tuse_rt);
    s = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        if (tuses[i] != 3 && produces(k, regs[i]) && pipe[k].tnew > tuses[i]) s = 1;
    return D_valid && s;
  endfunction

  function automatic logic [1:0] m_dfwd(int r, int tuse);
    if (tuse == 3) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (produces(k, r)) return (pipe[k].tnew == 0) ? 2'(k + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_efwd(int r);
    for (int k = 1; k < 3; k++)
      if (produces(k, r) && pipe[k].tnew == 0) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic model_advance(bit st);
    rec_t nxt [3];
    nxt[2] = pipe[1];
    nxt[2].tnew = 0;
    nxt[1] = pipe[0];
    nxt[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
    if (st) nxt[0] = '{default: 0};
    else nxt[0] = '{valid: D_valid, regwr: D_regwr, dst: int'(D_dst), tnew: int'(D_tnew),
                    rs: int'(D_rs), rt: int'(D_rt)};
    pipe = nxt;
  endtask

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".stall"},    {1'b0, stall}, {1'b0, m_stall()});
    chk({tag, ".fwd_D_rs"}, fwd_D_rs, m_dfwd(int'(D_rs), int'(D_tuse_rs)));
    chk({tag, ".fwd_D_rt"}, fwd_D_rt, m_dfwd(int'(D_rt), int'(D_tuse_rt)));
    chk({tag, ".fwd_E_rs"}, fwd_E_rs, m_efwd(pipe[0].rs));
    chk({tag, ".fwd_E_rt"}, fwd_E_rt, m_efwd(pipe[0].rt));
    chk({tag, ".fwd_M_rt"}, fwd_M_rt, produces(2, pipe[1].rt) ? 2'd3 : 2'd0);
  endtask

  task automatic set_d(int v, int rs, int rt, int trs, int trt, int wr, int dst, int tn);
    D_valid   = 1'(v);
    D_rs      = 5'(rs);
    D_rt      = 5'(rt);
    D_tuse_rs = 2'(trs);
    D_tuse_rt = 2'(trt);
    D_regwr   = 1'(wr);
    D_dst     = 5'(dst);
    D_tnew    = 2'(tn);
  endtask

  // One clock: check against model mid-cycle, then let the edge advance DUT and model together.
  task automatic cycle();
    bit st;
    @(negedge clk);
    check_model("cyc");
    st = m_stall();
    @(posedge clk);
    #1;
    model_advance(st);
  endtask

  task automatic flush();
    set_d(0, 0, 0, 3, 3, 0, 0, 0);
    repeat (3) cycle();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    model_clear();
    #1 check_model("rst");
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_d(0, 0, 0, 3, 3, 0, 0, 0);
    model_clear();
    #3;
    chk("reset.stall",    {1'b0, stall}, 2'd0);
    chk("reset.fwd_D_rs", fwd_D_rs, 2'd0);
    chk("reset.fwd_D_rt", fwd_D_rt, 2'd0);
    chk("reset.fwd_E_rs", fwd_E_rs, 2'd0);
    chk("reset.fwd_E_rt", fwd_E_rt, 2'd0);
    chk("reset.fwd_M_rt", fwd_M_rt, 2'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // lw $8 (tnew 2) then add using $8 in E: one stall, then forwarded from W in E.
    set_d(1, 0, 0, 3, 3, 1, 8, 2);
    cycle();
    set_d(1, 8, 0, 1, 3, 1, 10, 1);
    #1 chk("lw_add.stall", {1'b0, stall}, 2'd1);
    cycle();
    #1 chk("lw_add.release", {1'b0, stall}, 2'd0);
    cycle();
    set_d(0, 0, 0, 3, 3, 0, 0, 0);
    #1 chk("lw_add.fwd_E_rs", fwd_E_rs, 2'd3);
    flush();

    // add $9 (tnew 1) then beq $9 in D: stall, then forward from M.
    set_d(1, 0, 0, 3, 3, 1, 9, 1);
    cycle();
    set_d(1, 9, 0, 0, 3, 0, 0, 0);
    #1 chk("add_beq.stall", {1'b0, stall}, 2'd1);
    cycle();
    #1 chk("add_beq.release", {1'b0, stall}, 2'd0);
    chk("add_beq.fwd_D_rs", fwd_D_rs, 2'd2);
    flush();

    // jal $31 (tnew 0) then jr $31: no stall, forward from E.
    set_d(1, 0, 0, 3, 3, 1, 31, 0);
    cycle();
    set_d(1, 31, 0, 0, 3, 0, 0, 0);
    #1 chk("jal_jr.stall", {1'b0, stall}, 2'd0);
    chk("jal_jr.fwd_D_rs", fwd_D_rs, 2'd1);
    flush();

    // Two ready producers of $5 in E and M: nearer E wins for sw rt.
    set_d(1, 0, 0, 3, 3, 1, 5, 0);
    cycle();
    cycle();
    set_d(1, 0, 5, 3, 2, 0, 0, 0);
    #1 chk("ori_sw.stall", {1'b0, stall}, 2'd0);
    chk("ori_sw.fwd_D_rt", fwd_D_rt, 2'd1);
    flush();

    // Writes to $0 never create hazards.
    set_d(1, 0, 0, 3, 3, 1, 0, 1);
    cycle();
    set_d(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0.stall", {1'b0, stall}, 2'd0);
    chk("r0.fwd_D_rs", fwd_D_rs, 2'd0);
    flush();

    // lw $4 then sw rt=$4: no stall, store data forwarded from W while sw is in M.
    set_d(1, 0, 0, 3, 3, 1, 4, 2);
    cycle();
    set_d(1, 0, 4, 1, 2, 0, 0, 0);
    #1 chk("lw_sw.stall", {1'b0, stall}, 2'd0);
    cycle();
    set_d(0, 0, 0, 3, 3, 0, 0, 0);
    #1 chk("lw_sw.fwd_E_rt", fwd_E_rt, 2'd0);
    cycle();
    #1 chk("lw_sw.fwd_M_rt", fwd_M_rt, 2'd3);
    flush();

    // Async reset while a stall is pending drops it immediately.
    set_d(1, 0, 0, 3, 3, 1, 8, 2);
    cycle();
    set_d(1, 8, 0, 1, 3, 0, 0, 0);
    #1 chk("rst_mid.stall_before", {1'b0, stall}, 2'd1);
    reset = 1'b0;
    model_clear();
    #1 chk("rst_mid.stall_after", {1'b0, stall}, 2'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Random traffic on a small register set so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      set_d($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 4), $urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
